// File: rtl/bus_ctrl_pkg.sv
// Shared types and helpers for the snooping bus controller (snoop_bus_ctrl).
package bus_ctrl_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SNOOP = 3'd1,
    C2C   = 3'd2,
    C2CWB = 3'd3,
    L2RD  = 3'd4,
    WB    = 3'd5,
    DONE  = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    REQ_RD  = 2'd0,
    REQ_RFO = 2'd1,
    REQ_WB  = 2'd2
  } req_e;

  function automatic int bw_of(input int block_size);
    return block_size * WORD_W;
  endfunction

endpackage

// File: rtl/bus_arbiter.sv
// Request arbiter for the snooping bus controller.
// BUS_CTRL_RR_ARB_EN selects round-robin from ptr; otherwise fixed priority, lowest index wins.
module bus_arbiter #(
  parameter int CPUS = 2,
  parameter int IDXW = $clog2(CPUS)
) (
  input  logic [CPUS-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [CPUS-1:0] gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_valid
);

  logic [IDXW-1:0] start_s;

`ifdef BUS_CTRL_RR_ARB_EN
  assign start_s = ptr;
`else
  logic unused_ptr_s;
  assign unused_ptr_s = ^ptr;
  assign start_s      = '0;
`endif

  // Scan upward from the start index with wrap; first requester found wins
  always_comb begin
    int   idx;
    logic hit_s;
    idx       = 0;
    hit_s     = 1'b0;
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int i = 0; i < CPUS; i++) begin
      idx       = int'(start_s) + i;
      idx       = (idx >= CPUS) ? (idx - CPUS) : idx;
      hit_s     = !gnt_valid && req[idx];
      gnt[idx]  = hit_s;
      gnt_idx   = hit_s ? IDXW'(idx) : gnt_idx;
      gnt_valid = gnt_valid | hit_s;
    end
  end

endmodule

// File: rtl/snoop_bus_ctrl.sv
// Coherence bus responder: arbitrates CPU requests, snoops peers, fills cache-to-cache or from L2.
// Optional round-robin arbitration with BUS_CTRL_RR_ARB_EN.
module snoop_bus_ctrl
  import bus_ctrl_pkg::*;
#(
  parameter  int CPUS       = 2,
  parameter  int BLOCK_SIZE = 2,
  parameter  int ADDR_WIDTH = 32,
  localparam int BW         = bw_of(BLOCK_SIZE),
  localparam int IDXW       = $clog2(CPUS)
) (
  input  logic                                 CLK,
  input  logic                                 nRST,
  input  logic [CPUS-1:0]                      dREN,
  input  logic [CPUS-1:0]                      dWEN,
  input  logic [CPUS-1:0]                      ccwrite,
  input  logic [CPUS-1:0][ADDR_WIDTH-1:0]      daddr,
  input  logic [CPUS-1:0][BW-1:0]              dstore,
  input  logic [CPUS-1:0]                      ccsnoopdone,
  input  logic [CPUS-1:0]                      ccsnoophit,
  input  logic [CPUS-1:0]                      ccdirty,
  output logic [CPUS-1:0]                      dwait,
  output logic [CPUS-1:0][BW-1:0]              dload,
  output logic [CPUS-1:0]                      ccexclusive,
  output logic [CPUS-1:0]                      ccwait,
  output logic [CPUS-1:0]                      ccinv,
  output logic [CPUS-1:0][ADDR_WIDTH-1:0]      ccsnoopaddr,
  output logic [ADDR_WIDTH-1:0]                l2_addr,
  output logic                                 l2_ren,
  output logic                                 l2_wen,
  output logic [BW-1:0]                        l2_store,
  input  logic [BW-1:0]                        l2_load,
  input  logic                                 l2_busy
);

  state_e                  state_r, state_nxt_s;
  req_e                    type_r, gnt_type_s;
  logic [IDXW-1:0]         ptr_r, ptr_nxt_s;
  logic [IDXW-1:0]         req_id_r, resp_r, resp_s;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [CPUS-1:0]         hit_r, dirty_r;
  logic [BW-1:0]           data_r;

  logic [CPUS-1:0]         req_s, gnt_s, self_s, snoop_hit_s;
  logic [IDXW-1:0]         gnt_idx_s;
  logic                    gnt_valid_s, snoop_done_s;

  assign req_s = dREN | dWEN | ccwrite;

  bus_arbiter #(
    .CPUS (CPUS),
    .IDXW (IDXW)
  ) u_arb (
    .req       (req_s),
    .ptr       (ptr_r),
    .gnt       (gnt_s),
    .gnt_idx   (gnt_idx_s),
    .gnt_valid (gnt_valid_s)
  );

  // Request type of the granted CPU: writeback beats RFO beats read
  always_comb begin
    gnt_type_s = REQ_RD;
    if (|(dWEN & gnt_s)) begin
      gnt_type_s = REQ_WB;
    end else if (|(ccwrite & gnt_s)) begin
      gnt_type_s = REQ_RFO;
    end else begin
      gnt_type_s = REQ_RD;
    end
  end

  // Snoop bookkeeping: the requester is excluded; responder is the lowest-index hit
  always_comb begin
    self_s          = '0;
    self_s[req_id_r] = 1'b1;
    snoop_done_s    = &(ccsnoopdone | self_s);
    snoop_hit_s     = ccsnoophit & ~self_s;
    resp_s          = '0;
    for (int i = CPUS - 1; i >= 0; i--) begin
      resp_s = snoop_hit_s[i] ? IDXW'(i) : resp_s;
    end
  end

`ifdef BUS_CTRL_RR_ARB_EN
  assign ptr_nxt_s = (req_id_r == IDXW'(CPUS - 1)) ? '0 : (req_id_r + IDXW'(1));
`else
  assign ptr_nxt_s = '0;
`endif

  // State and transaction registers
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_r  <= IDLE;
      type_r   <= REQ_RD;
      ptr_r    <= '0;
      req_id_r <= '0;
      resp_r   <= '0;
      addr_r   <= '0;
      hit_r    <= '0;
      dirty_r  <= '0;
      data_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        IDLE: begin
          if (gnt_valid_s) begin
            req_id_r <= gnt_idx_s;
            type_r   <= gnt_type_s;
            addr_r   <= daddr[gnt_idx_s];
            hit_r    <= '0;
            dirty_r  <= '0;
            data_r   <= '0;
          end
        end
        SNOOP: begin
          if (snoop_done_s) begin
            hit_r   <= snoop_hit_s;
            dirty_r <= ccdirty & ~self_s;
            resp_r  <= resp_s;
          end
        end
        C2C:     data_r <= dstore[resp_r];
        L2RD:    if (!l2_busy) data_r <= l2_load;
        DONE:    ptr_r <= ptr_nxt_s;
        default: ;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (gnt_valid_s) begin
          state_nxt_s = (gnt_type_s == REQ_WB) ? WB : SNOOP;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SNOOP: begin
        if (snoop_done_s) begin
          state_nxt_s = (|snoop_hit_s) ? C2C : L2RD;
        end else begin
          state_nxt_s = SNOOP;
        end
      end
      C2C:     state_nxt_s = dirty_r[resp_r] ? C2CWB : DONE;
      C2CWB:   state_nxt_s = l2_busy ? C2CWB : DONE;
      L2RD:    state_nxt_s = l2_busy ? L2RD : DONE;
      WB:      state_nxt_s = l2_busy ? WB : DONE;
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode from state and latched transaction
  always_comb begin
    dwait       = '1;
    dload       = '0;
    ccexclusive = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    l2_addr     = '0;
    l2_ren      = 1'b0;
    l2_wen      = 1'b0;
    l2_store    = '0;
    case (state_r)
      SNOOP: begin
        for (int j = 0; j < CPUS; j++) begin
          ccwait[j]      = ~self_s[j];
          ccinv[j]       = ~self_s[j] & (type_r == REQ_RFO);
          ccsnoopaddr[j] = self_s[j] ? '0 : addr_r;
        end
      end
      C2C: begin
        ccwait[resp_r]      = 1'b1;
        ccsnoopaddr[resp_r] = addr_r;
      end
      C2CWB: begin
        l2_wen   = 1'b1;
        l2_addr  = addr_r;
        l2_store = data_r;
      end
      L2RD: begin
        l2_ren  = 1'b1;
        l2_addr = addr_r;
      end
      WB: begin
        l2_wen   = 1'b1;
        l2_addr  = addr_r;
        l2_store = dstore[req_id_r];
      end
      DONE: begin
        dwait[req_id_r]       = 1'b0;
        dload[req_id_r]       = data_r;
        ccexclusive[req_id_r] = ~(|hit_r) & (type_r != REQ_WB);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// Scoreboard bench for snoop_bus_ctrl; grant-order expectations follow BUS_CTRL_RR_ARB_EN.
module tb_snoop_bus_ctrl;

  localparam int CPUS       = 2;
  localparam int BLOCK_SIZE = 2;
  localparam int ADDR_WIDTH = 32;
  localparam int BW         = BLOCK_SIZE * 32;

  logic                            CLK;
  logic                            nRST;
  logic [CPUS-1:0]                 dREN, dWEN, ccwrite;
  logic [CPUS-1:0][ADDR_WIDTH-1:0] daddr;
  logic [CPUS-1:0][BW-1:0]         dstore;
  logic [CPUS-1:0]                 ccsnoopdone, ccsnoophit, ccdirty;
  logic [CPUS-1:0]                 dwait, ccexclusive, ccwait, ccinv;
  logic [CPUS-1:0][BW-1:0]         dload;
  logic [CPUS-1:0][ADDR_WIDTH-1:0] ccsnoopaddr;
  logic [ADDR_WIDTH-1:0]           l2_addr;
  logic                            l2_ren, l2_wen, l2_busy;
  logic [BW-1:0]                   l2_store, l2_load;

  typedef struct {
    int            cpu;
    logic [BW-1:0] data;
    logic          excl;
    bit            chk_data;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc_cnt  = 0;
  int   t0;
  bit   ccwait_seen, l2_seen;

  snoop_bus_ctrl #(
    .CPUS       (CPUS),
    .BLOCK_SIZE (BLOCK_SIZE),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .dREN        (dREN),
    .dWEN        (dWEN),
    .ccwrite     (ccwrite),
    .daddr       (daddr),
    .dstore      (dstore),
    .ccsnoopdone (ccsnoopdone),
    .ccsnoophit  (ccsnoophit),
    .ccdirty     (ccdirty),
    .dwait       (dwait),
    .dload       (dload),
    .ccexclusive (ccexclusive),
    .ccwait      (ccwait),
    .ccinv       (ccinv),
    .ccsnoopaddr (ccsnoopaddr),
    .l2_addr     (l2_addr),
    .l2_ren      (l2_ren),
    .l2_wen      (l2_wen),
    .l2_store    (l2_store),
    .l2_load     (l2_load),
    .l2_busy     (l2_busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int cpu, input logic [BW-1:0] data, input logic excl, input bit chk_data);
    exp_t e;
    e.cpu = cpu; e.data = data; e.excl = excl; e.chk_data = chk_data;
    sb_q.push_back(e);
  endtask

  task automatic go_edge();
    @(posedge CLK);
    #1;
    t0 = cyc_cnt;
  endtask

  task automatic wait_ccwait(input int s);
    int n = 0;
    do begin @(negedge CLK); n++; end while (!ccwait[s] && n < 40);
    check_val("wait_ccwait", {127'd0, ccwait[s]}, 128'd1);
  endtask

  task automatic wait_l2wen();
    int n = 0;
    do begin @(negedge CLK); n++; end while (!l2_wen && n < 40);
    check_val("wait_l2wen", {127'd0, l2_wen}, 128'd1);
  endtask

  task automatic wait_done(input int c);
    int n = 0;
    do begin @(negedge CLK); n++; end while (dwait[c] && n < 40);
    check_val("wait_done", {127'd0, dwait[c]}, 128'd0);
  endtask

  // Called at the negedge where the snooped CPU sees ccwait; answers it for one cycle
  task automatic snoop_resp(input int s, input logic hit, input logic dirty, input logic [BW-1:0] data);
    ccsnoopdone[s] = 1'b1;
    ccsnoophit[s]  = hit;
    ccdirty[s]     = dirty;
    dstore[s]      = data;
    @(negedge CLK);
    ccsnoopdone[s] = 1'b0;
    ccsnoophit[s]  = 1'b0;
    ccdirty[s]     = 1'b0;
  endtask

  initial forever begin
    @(posedge CLK);
    cyc_cnt++;
  end

  // Completion monitor: every dwait low pops one scoreboard entry
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (ccwait != '0) ccwait_seen = 1'b1;
      if (l2_ren || l2_wen) l2_seen = 1'b1;
      for (int i = 0; i < CPUS; i++) begin
        if (nRST && !dwait[i]) begin
          if (sb_q.size() == 0) begin
            check_val("unexpected_done", {127'd0, dwait[i]}, 128'd1);
          end else begin
            e = sb_q.pop_front();
            check_val("done_cpu", i, e.cpu);
            if (e.chk_data) check_val("dload", dload[i], e.data);
            check_val("ccexclusive", {127'd0, ccexclusive[i]}, {127'd0, e.excl});
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int exp_cpu;
    logic [BW-1:0] d;
    nRST = 1'b0; dREN = '0; dWEN = '0; ccwrite = '0; daddr = '0; dstore = '0;
    ccsnoopdone = '0; ccsnoophit = '0; ccdirty = '0; l2_load = '0; l2_busy = 1'b0;
    ccwait_seen = 1'b0; l2_seen = 1'b0;
    repeat (2) @(negedge CLK);
    check_val("rst_dwait", dwait, 2'b11);
    check_val("rst_ctl", {ccwait, ccinv, ccexclusive, l2_ren, l2_wen}, 8'd0);
    check_val("rst_data", {dload, l2_store}, 192'd0);
    check_val("rst_addr", {ccsnoopaddr, l2_addr}, 96'd0);
    nRST = 1'b1;

    // T1: CPU0 read, no hits, L2 busy for three cycles
    l2_busy = 1'b1;
    l2_load = 64'hAAAA_BBBB_CCCC_DDDD;
    go_edge();
    dREN[0] = 1'b1; daddr[0] = 32'h100;
    push_exp(0, 64'hAAAA_BBBB_CCCC_DDDD, 1'b1, 1'b1);
    wait_ccwait(1);
    check_val("t1_snoopaddr", ccsnoopaddr[1], 32'h100);
    check_val("t1_inv_self", {ccinv[1], ccwait[0]}, 2'b00);
    snoop_resp(1, 1'b0, 1'b0, '0);
    check_val("t1_l2", {l2_ren, l2_wen, l2_addr}, {2'b10, 32'h100});
    repeat (2) @(negedge CLK);
    check_val("t1_ren_hold", {127'd0, l2_ren}, 128'd1);
    @(negedge CLK);
    l2_busy = 1'b0;
    wait_done(0);
    dREN[0] = 1'b0;
    @(negedge CLK);
    check_val("t1_dwait_1cyc", {127'd0, dwait[0]}, 128'd1);

    // T2: CPU1 RFO, CPU0 hits dirty -> c2c plus L2 writeback
    go_edge();
    ccwrite[1] = 1'b1; daddr[1] = 32'h200;
    push_exp(1, 64'h1111_2222, 1'b0, 1'b1);
    wait_ccwait(0);
    check_val("t2_inv", {ccinv[0], ccwait[1]}, 2'b10);
    check_val("t2_snoopaddr", ccsnoopaddr[0], 32'h200);
    snoop_resp(0, 1'b1, 1'b1, 64'h1111_2222);
    check_val("t2_c2c_hold", ccwait, 2'b01);
    wait_l2wen();
    check_val("t2_wb", {l2_ren, l2_addr, l2_store}, {1'b0, 32'h200, 64'h1111_2222});
    wait_done(1);
    ccwrite[1] = 1'b0;

    // T3: CPU0 read, CPU1 hits clean -> no L2 traffic
    go_edge();
    dREN[0] = 1'b1; daddr[0] = 32'h180;
    l2_seen = 1'b0;
    push_exp(0, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b1);
    wait_ccwait(1);
    snoop_resp(1, 1'b1, 1'b0, 64'h0123_4567_89AB_CDEF);
    wait_done(0);
    check_val("t3_latency", cyc_cnt - t0, 3);
    check_val("t3_no_l2", {127'd0, l2_seen}, 128'd0);
    dREN[0] = 1'b0;

    // T4: CPU1 writeback, no snoop
    go_edge();
    dWEN[1] = 1'b1; daddr[1] = 32'h300; dstore[1] = 64'h5;
    ccwait_seen = 1'b0;
    push_exp(1, '0, 1'b0, 1'b0);
    wait_l2wen();
    check_val("t4_wb", {l2_ren, l2_addr, l2_store}, {1'b0, 32'h300, 64'h5});
    wait_done(1);
    check_val("t4_latency", cyc_cnt - t0, 2);
    check_val("t4_no_ccwait", {127'd0, ccwait_seen}, 128'd0);
    dWEN[1] = 1'b0;

    // T5: both CPUs request continuously
    go_edge();
    dREN = 2'b11; daddr[0] = 32'h500; daddr[1] = 32'h600;
    for (int k = 0; k < 4; k++) begin
`ifdef BUS_CTRL_RR_ARB_EN
      exp_cpu = k % 2;
`else
      exp_cpu = 0;
`endif
      d = 64'hC0DE_0000_0000_0000 | 64'(k);
      l2_load = d;
      push_exp(exp_cpu, d, 1'b1, 1'b1);
      wait_ccwait(1 - exp_cpu);
      check_val("t5_snoopaddr", ccsnoopaddr[1 - exp_cpu], (exp_cpu == 1) ? 32'h600 : 32'h500);
      snoop_resp(1 - exp_cpu, 1'b0, 1'b0, '0);
      wait_done(exp_cpu);
    end
    dREN = 2'b00;

    // T6: reset while in L2RD abandons the transaction
    l2_busy = 1'b1;
    go_edge();
    dREN[0] = 1'b1; daddr[0] = 32'h400;
    wait_ccwait(1);
    snoop_resp(1, 1'b0, 1'b0, '0);
    check_val("t6_in_l2rd", {127'd0, l2_ren}, 128'd1);
    nRST = 1'b0;
    @(negedge CLK);
    check_val("t6_rst_dwait", dwait, 2'b11);
    check_val("t6_rst_ctl", {ccwait, ccinv, ccexclusive, l2_ren, l2_wen}, 8'd0);
    check_val("t6_rst_data", {dload, l2_store}, 192'd0);
    check_val("t6_rst_addr", {ccsnoopaddr, l2_addr}, 96'd0);
    dREN[0] = 1'b0; nRST = 1'b1; l2_busy = 1'b0;
    repeat (3) @(negedge CLK);
    check_val("t6_idle_after", {dwait, ccwait, l2_ren}, {2'b11, 2'b00, 1'b0});

    check_val("sb_leftover", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
